// File: rtl/axi_lite_regbank.sv
// -----------------------------------------------------------------------------
// axi_lite_regbank
//
// Parametrised AXI4-Lite slave register bank. It provides C_NUM_CTRL read/write
// control words, C_NUM_STAT read-only status words and, when the
// AXI_REGBANK_IRQ_EN macro is defined, a PEND (write-1-to-clear) / MASK
// interrupt block with a registered level interrupt.
//
// Word map (word index = addr[A-1:2], addr[1:0] ignored):
//   0 .. C_NUM_CTRL-1                 CTRL  RW, byte strobes honoured
//   next C_NUM_STAT words             STAT  RO (writes get SLVERR)
//   next word                         PEND  W1C   (AXI_REGBANK_IRQ_EN only)
//   next word                         MASK  RW    (AXI_REGBANK_IRQ_EN only)
//   anything else                     unmapped: SLVERR, reads return 0
//
// Ports
//   s00_axi_aclk      single clock, rising edge
//   s00_axi_areset    synchronous, active-high reset
//   s00_axi_aw*/w*/b* AXI4-Lite write address, write data, write response
//   s00_axi_ar*/r*    AXI4-Lite read address, read data
//   ctrl_o            control words, word i = ctrl_o[i*W +: W]
//   ctrl_wr_pulse_o   bit i high for one cycle together with the CTRL word i update
//   stat_i            status words, synchronous to s00_axi_aclk
//   evt_i             event levels, sampled every cycle (AXI_REGBANK_IRQ_EN only)
//   irq_o             level interrupt = registered |(PEND & MASK) (AXI_REGBANK_IRQ_EN only)
//
// Each channel is a two-state FSM (IDLE -> RESP/DATA). A request is accepted
// in the cycle both its valids are present while IDLE, and the response is
// valid on the following cycle, giving one transaction per two cycles.
// -----------------------------------------------------------------------------
module axi_lite_regbank #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int C_NUM_CTRL         = 8,
  parameter int C_NUM_STAT         = 4
) (
  input  logic                                       s00_axi_aclk,
  input  logic                                       s00_axi_areset,
  output logic [C_NUM_CTRL*C_S_AXI_DATA_WIDTH-1:0]   ctrl_o,
  output logic [C_NUM_CTRL-1:0]                      ctrl_wr_pulse_o,
  input  logic [C_NUM_STAT*C_S_AXI_DATA_WIDTH-1:0]   stat_i,
`ifdef AXI_REGBANK_IRQ_EN
  input  logic [C_S_AXI_DATA_WIDTH-1:0]              evt_i,
  output logic                                       irq_o,
`endif
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]              s00_axi_awaddr,
  input  logic [2:0]                                 s00_axi_awprot,
  input  logic                                       s00_axi_awvalid,
  output logic                                       s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]              s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]            s00_axi_wstrb,
  input  logic                                       s00_axi_wvalid,
  output logic                                       s00_axi_wready,
  output logic [1:0]                                 s00_axi_bresp,
  output logic                                       s00_axi_bvalid,
  input  logic                                       s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]              s00_axi_araddr,
  input  logic [2:0]                                 s00_axi_arprot,
  input  logic                                       s00_axi_arvalid,
  output logic                                       s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]              s00_axi_rdata,
  output logic [1:0]                                 s00_axi_rresp,
  output logic                                       s00_axi_rvalid,
  input  logic                                       s00_axi_rready
);

  localparam int W  = C_S_AXI_DATA_WIDTH;
  localparam int A  = C_S_AXI_ADDR_WIDTH;
  localparam int NB = W / 8;

  localparam logic [31:0] STAT_BASE = 32'(C_NUM_CTRL);
`ifdef AXI_REGBANK_IRQ_EN
  localparam logic [31:0] PEND_IDX  = 32'(C_NUM_CTRL + C_NUM_STAT);
  localparam logic [31:0] MASK_IDX  = 32'(C_NUM_CTRL + C_NUM_STAT + 1);
`endif

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  // Expand byte strobes into a per-bit write mask.
  function automatic logic [W-1:0] strb_mask(input logic [NB-1:0] strb);
    logic [W-1:0] m;
    m = '0;
    for (int k = 0; k < NB; k++) m[k*8 +: 8] = {8{strb[k]}};
    return m;
  endfunction

  // Protection bits and the byte offset carry no meaning for this bank.
  logic unused_ok;
  assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot,
                       s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  logic [31:0] widx, ridx;
  assign widx = 32'(s00_axi_awaddr[A-1:2]);
  assign ridx = 32'(s00_axi_araddr[A-1:2]);

  w_state_e                    w_state_q, w_state_d;
  r_state_e                    r_state_q, r_state_d;
  logic [C_NUM_CTRL-1:0][W-1:0] ctrl_q, ctrl_d;
  logic [C_NUM_CTRL-1:0]       pulse_q, pulse_d;
  logic [1:0]                  bresp_q, bresp_d;
  logic [W-1:0]                rdata_q, rdata_d;
  logic [1:0]                  rresp_q, rresp_d;
  logic                        wr_fire, rd_fire;
  logic [W-1:0]                wmask;
`ifdef AXI_REGBANK_IRQ_EN
  logic [W-1:0]                pend_q, pend_d, mask_q, mask_d, pend_clr;
  logic                        irq_q, irq_d;
`endif

  // Acceptance is gated by reset so the ready outputs read 0 while in reset
  // even if a master keeps its valids high.
  assign wr_fire = (w_state_q == W_IDLE) && s00_axi_awvalid && s00_axi_wvalid && !s00_axi_areset;
  assign rd_fire = (r_state_q == R_IDLE) && s00_axi_arvalid && !s00_axi_areset;
  assign wmask   = strb_mask(s00_axi_wstrb);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every flop samples the
  // pre-edge value of the others; blocking here would create ordering races.
  // NOTE: the CTRL words are individual flops that software expects to read as
  // zero after reset, so they are reset explicitly rather than left as an
  // unreset storage array.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      ctrl_q    <= '0;
      pulse_q   <= '0;
      bresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
`ifdef AXI_REGBANK_IRQ_EN
      pend_q    <= '0;
      mask_q    <= '0;
      irq_q     <= 1'b0;
`endif
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      ctrl_q    <= ctrl_d;
      pulse_q   <= pulse_d;
      bresp_q   <= bresp_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
`ifdef AXI_REGBANK_IRQ_EN
      pend_q    <= pend_d;
      mask_q    <= mask_d;
      irq_q     <= irq_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Write FSM next state and register commit
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned here receives a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_state_d = w_state_q;
    bresp_d   = bresp_q;
    ctrl_d    = ctrl_q;
    pulse_d   = '0;
`ifdef AXI_REGBANK_IRQ_EN
    mask_d    = mask_q;
    pend_clr  = '0;
`endif
    case (w_state_q)
      W_IDLE: begin
        if (wr_fire) begin
          w_state_d = W_RESP;
          bresp_d   = RESP_SLVERR;
          for (int i = 0; i < C_NUM_CTRL; i++) begin
            if (widx == 32'(i)) begin
              ctrl_d[i]  = (ctrl_q[i] & ~wmask) | (s00_axi_wdata & wmask);
              pulse_d[i] = |s00_axi_wstrb;
              bresp_d    = RESP_OKAY;
            end
          end
`ifdef AXI_REGBANK_IRQ_EN
          if (widx == PEND_IDX) begin
            pend_clr = s00_axi_wdata & wmask;
            bresp_d  = RESP_OKAY;
          end
          if (widx == MASK_IDX) begin
            mask_d  = (mask_q & ~wmask) | (s00_axi_wdata & wmask);
            bresp_d = RESP_OKAY;
          end
`endif
        end
      end
      W_RESP: begin
        if (s00_axi_bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

`ifdef AXI_REGBANK_IRQ_EN
  // The set term is OR-ed in after the clear so a coincident event wins.
  always_comb begin
    pend_d = (pend_q & ~pend_clr) | evt_i;
    irq_d  = |(pend_q & mask_q);
  end
`endif

  // ---------------------------------------------------------------------------
  // Read FSM next state and capture. Registers are sampled in the accept cycle,
  // so a read coinciding with a write to the same word returns the old value.
  // ---------------------------------------------------------------------------
  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (rd_fire) begin
          r_state_d = R_DATA;
          rdata_d   = '0;
          rresp_d   = RESP_SLVERR;
          for (int i = 0; i < C_NUM_CTRL; i++) begin
            if (ridx == 32'(i)) begin
              rdata_d = ctrl_q[i];
              rresp_d = RESP_OKAY;
            end
          end
          for (int i = 0; i < C_NUM_STAT; i++) begin
            if (ridx == STAT_BASE + 32'(i)) begin
              rdata_d = stat_i[i*W +: W];
              rresp_d = RESP_OKAY;
            end
          end
`ifdef AXI_REGBANK_IRQ_EN
          if (ridx == PEND_IDX) begin
            rdata_d = pend_q;
            rresp_d = RESP_OKAY;
          end
          if (ridx == MASK_IDX) begin
            rdata_d = mask_q;
            rresp_d = RESP_OKAY;
          end
`endif
        end
      end
      R_DATA: begin
        if (s00_axi_rready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    s00_axi_awready = wr_fire;
    s00_axi_wready  = wr_fire;
    s00_axi_bvalid  = (w_state_q == W_RESP);
    s00_axi_bresp   = bresp_q;
    s00_axi_arready = rd_fire;
    s00_axi_rvalid  = (r_state_q == R_DATA);
    s00_axi_rdata   = rdata_q;
    s00_axi_rresp   = rresp_q;
  end

  assign ctrl_o          = ctrl_q;
  assign ctrl_wr_pulse_o = pulse_q;
`ifdef AXI_REGBANK_IRQ_EN
  assign irq_o           = irq_q;
`endif

endmodule
